// File: rtl/blink_sched.sv
// Blink scheduler: after a start edge, issues toggle pulses for an LED state block every
// PRESCALE*period clock cycles, either a fixed number of times or continuously until stopped.
module blink_sched #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] period,
  input  logic [3:0] count,
  output logic       transition,
  output logic       busy,
  output logic       done,
  output logic [3:0] remaining
);

  localparam logic [15:0] PreMax = 16'(PRESCALE - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pre_q, pre_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic [7:0]  period_q, period_d;
  logic [3:0]  rem_q, rem_d;
  logic        trans_q, trans_d;
  logic        done_q, done_d;
  logic        start_q;
  // Set once start has been seen low since reset, so a start held across reset is not an edge.
  logic        start_low_q;

  logic start_edge;
  logic tick;
  logic expiry;

  assign start_edge = start & ~start_q & start_low_q;
  assign tick       = (pre_q == PreMax);
  assign expiry     = tick && (tcnt_q == period_q - 8'd1);

  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    tcnt_d   = tcnt_q;
    period_d = period_q;
    rem_d    = rem_q;
    trans_d  = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        pre_d  = 16'd0;
        tcnt_d = 8'd0;
        if (start_edge && !stop) begin
          period_d = (period == 8'd0) ? 8'd1 : period;
          rem_d    = count;
          state_d  = StRun;
        end
      end

      StRun: begin
        if (stop) begin
          state_d = StIdle;
          rem_d   = 4'd0;
          pre_d   = 16'd0;
          tcnt_d  = 8'd0;
        end else begin
          pre_d = tick ? 16'd0 : pre_q + 16'd1;
          if (tick) begin
            tcnt_d = expiry ? 8'd0 : tcnt_q + 8'd1;
          end
          if (expiry) begin
            trans_d = 1'b1;
            // A nonzero remaining count in RUN means finite mode.
            if (rem_q != 4'd0) begin
              rem_d = rem_q - 4'd1;
              if (rem_q == 4'd1) begin
                state_d = StDone;
                done_d  = 1'b1;
              end
            end
          end
        end
      end

      StDone: begin
        state_d = StIdle;
        rem_d   = 4'd0;
        pre_d   = 16'd0;
        tcnt_d  = 8'd0;
      end

      default: begin
        state_d = StIdle;
        rem_d   = 4'd0;
        pre_d   = 16'd0;
        tcnt_d  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      pre_q       <= 16'd0;
      tcnt_q      <= 8'd0;
      period_q    <= 8'd0;
      rem_q       <= 4'd0;
      trans_q     <= 1'b0;
      done_q      <= 1'b0;
      start_q     <= 1'b0;
      start_low_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      tcnt_q      <= tcnt_d;
      period_q    <= period_d;
      rem_q       <= rem_d;
      trans_q     <= trans_d;
      done_q      <= done_d;
      start_q     <= start;
      start_low_q <= start_low_q | ~start;
    end
  end

  assign transition = trans_q;
  assign done       = done_q;
  assign busy       = (state_q == StRun);
  assign remaining  = rem_q;

endmodule

// File: tb/tb_blink_sched.sv
// Directed bench for blink_sched: expected pulse cycles are queued at launch and checked
// against transition/done on every cycle.
module tb_blink_sched;

  logic       CLK;
  logic       RST;
  logic       start;
  logic       stop;
  logic [7:0] period;
  logic [3:0] count;
  logic       transition;
  logic       busy;
  logic       done;
  logic [3:0] remaining;

  blink_sched #(.PRESCALE(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .stop      (stop),
    .period    (period),
    .count     (count),
    .transition(transition),
    .busy      (busy),
    .done      (done),
    .remaining (remaining)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int unsigned at;
    logic        dn;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc;
  int unsigned vectors;
  int unsigned fails;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock edge; afterwards compare the pulse outputs against the scoreboard.
  task automatic step();
    exp_t e;
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
    if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
      e = exp_q.pop_front();
      chk("transition_pulse", 8'(transition), 8'd1);
      chk("done_with_pulse", 8'(done), 8'(e.dn));
    end else begin
      chk("transition_quiet", 8'(transition), 8'd0);
      chk("done_quiet", 8'(done), 8'd0);
    end
  endtask

  task automatic run_to(input int unsigned t);
    while (cyc < t) step();
  endtask

  task automatic launch(input logic [7:0] p, input logic [3:0] c, output int unsigned k);
    period = p;
    count  = c;
    start  = 1'b1;
    k      = cyc + 1;
    step();
    start  = 1'b0;
  endtask

  initial begin
    int unsigned k;
    cyc     = 0;
    vectors = 0;
    fails   = 0;
    RST     = 1'b1;
    start   = 1'b0;
    stop    = 1'b0;
    period  = 8'd0;
    count   = 4'd0;

    @(negedge CLK);
    step();
    step();
    chk("reset_busy", 8'(busy), 8'd0);
    chk("reset_remaining", 8'(remaining), 8'd0);
    RST = 1'b0;
    step();

    // Finite sequence: period 2, count 3.
    launch(8'd2, 4'd3, k);
    exp_q.push_back('{at: k + 8, dn: 1'b0});
    exp_q.push_back('{at: k + 16, dn: 1'b0});
    exp_q.push_back('{at: k + 24, dn: 1'b1});
    chk("fin_busy_start", 8'(busy), 8'd1);
    chk("fin_rem_start", 8'(remaining), 8'd3);
    run_to(k + 8);
    chk("fin_rem_1", 8'(remaining), 8'd2);
    run_to(k + 16);
    chk("fin_rem_2", 8'(remaining), 8'd1);
    chk("fin_busy_mid", 8'(busy), 8'd1);
    run_to(k + 24);
    chk("fin_rem_3", 8'(remaining), 8'd0);
    chk("fin_busy_done", 8'(busy), 8'd0);
    step();
    chk("fin_busy_idle", 8'(busy), 8'd0);
    repeat (3) step();

    // Zero period behaves as period 1.
    launch(8'd0, 4'd1, k);
    exp_q.push_back('{at: k + 4, dn: 1'b1});
    chk("zp_rem_start", 8'(remaining), 8'd1);
    chk("zp_busy_start", 8'(busy), 8'd1);
    run_to(k + 4);
    chk("zp_busy_done", 8'(busy), 8'd0);
    chk("zp_rem_done", 8'(remaining), 8'd0);
    repeat (3) step();
    chk("zp_busy_idle", 8'(busy), 8'd0);

    // Continuous mode, then stop.
    launch(8'd1, 4'd0, k);
    for (int n = 1; n <= 10; n++) exp_q.push_back('{at: k + 4 * n, dn: 1'b0});
    chk("cont_rem_start", 8'(remaining), 8'd0);
    run_to(k + 20);
    chk("cont_busy_mid", 8'(busy), 8'd1);
    chk("cont_rem_mid", 8'(remaining), 8'd0);
    run_to(k + 40);
    chk("cont_busy_end", 8'(busy), 8'd1);
    stop = 1'b1;
    step();
    chk("cont_stop_busy", 8'(busy), 8'd0);
    chk("cont_stop_rem", 8'(remaining), 8'd0);
    repeat (12) step();
    stop = 1'b0;
    step();

    // Stop sampled on the expiry edge wins.
    launch(8'd2, 4'd2, k);
    chk("soe_rem_start", 8'(remaining), 8'd2);
    run_to(k + 7);
    stop = 1'b1;
    step();
    chk("soe_busy", 8'(busy), 8'd0);
    chk("soe_rem", 8'(remaining), 8'd0);
    repeat (10) step();
    stop = 1'b0;
    step();

    // Start edge and period/count changes during RUN are ignored.
    launch(8'd2, 4'd2, k);
    exp_q.push_back('{at: k + 8, dn: 1'b0});
    exp_q.push_back('{at: k + 16, dn: 1'b1});
    run_to(k + 2);
    start  = 1'b1;
    period = 8'd7;
    count  = 4'd9;
    step();
    start  = 1'b0;
    run_to(k + 8);
    chk("ign_rem_1", 8'(remaining), 8'd1);
    chk("ign_busy_1", 8'(busy), 8'd1);
    run_to(k + 16);
    chk("ign_rem_2", 8'(remaining), 8'd0);
    chk("ign_busy_2", 8'(busy), 8'd0);
    repeat (2) step();

    // Reset on an expiry edge with start held high across reset.
    launch(8'd1, 4'd5, k);
    exp_q.push_back('{at: k + 4, dn: 1'b0});
    run_to(k + 7);
    RST   = 1'b1;
    start = 1'b1;
    step();
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_rem", 8'(remaining), 8'd0);
    RST = 1'b0;
    repeat (20) step();
    chk("rst_held_busy", 8'(busy), 8'd0);
    chk("rst_held_rem", 8'(remaining), 8'd0);
    start = 1'b0;
    step();
    launch(8'd1, 4'd1, k);
    exp_q.push_back('{at: k + 4, dn: 1'b1});
    chk("restart_busy", 8'(busy), 8'd1);
    chk("restart_rem", 8'(remaining), 8'd1);
    run_to(k + 4);
    chk("restart_busy_done", 8'(busy), 8'd0);
    repeat (3) step();

    chk("scoreboard_empty", 8'(exp_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/blink_sched.md
BLINK_SCHED -- requirements
Module: blink_sched

Interface
REQ-001 Parameter PRESCALE, default 4: CLK cycles per tick; legal range 1..65535.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RST  input  1  reset; synchronous and active-high.
REQ-004 start  input  1  level input; a rising edge requests a blink sequence.
REQ-005 stop  input  1  level input; while high, aborts any sequence.
REQ-006 period  input  8  ticks between toggle pulses; 0 treated as 1.
REQ-007 count  input  4  number of toggle pulses; 0 means continuous.
REQ-008 transition  output  1  registered one-cycle pulse that drives the toggle input of the LED state block.
REQ-009 busy  output  1  high while in RUN.
REQ-010 done  output  1  registered one-cycle pulse when a finite sequence completes.
REQ-011 remaining  output  4  pulses still to issue; 0 in continuous mode and in IDLE.

Function
REQ-012 Start detection:
- start_d register samples start every cycle.
- start_edge = start & ~start_d.
REQ-013 FSM states are IDLE, RUN and DONE; encoding is free.
REQ-014 IDLE behaviour:
- On start_edge with stop low: latch period_q = (period==0 ? 1 : period) and remaining = count.
- Clear the prescaler and tick counter, then go to RUN.
REQ-015 Prescaler, active in RUN:
- Counts 0..PRESCALE-1 and wraps.
- tick is high in the cycle the prescaler equals PRESCALE-1.
REQ-016 Tick counter, active in RUN:
- Advances on tick and counts 0..period_q-1.
- Expiry = tick while tick counter equals period_q-1; the counter then returns to 0.
REQ-017 On expiry in RUN, transition is high for exactly the next cycle.
REQ-018 On expiry with count mode finite (latched count != 0), remaining decrements by 1.
REQ-019 If the decrement in REQ-018 makes remaining 0, the FSM goes to DONE in the same edge.
REQ-020 Timing: with the start edge sampled at edge k, pulse n (n>=1) is high in the cycle after edge k + n*PRESCALE*period_q.
REQ-021 DONE lasts one cycle:
- done is high in that cycle, concurrent with the final transition.
- Next state is IDLE.
REQ-022 stop high in RUN or DONE forces IDLE on the next edge, with remaining cleared.
REQ-023 stop takes precedence over a simultaneous expiry: no transition, no done.
REQ-024 In IDLE, stop high suppresses start_edge.
REQ-025 A start_edge in RUN or DONE is ignored; period and count changes during RUN are ignored.
REQ-026 In continuous mode the FSM remains in RUN indefinitely:
- remaining stays 0.
- done never asserts.
REQ-027 transition and done are never high outside the cycles defined above; busy equals (state==RUN).

Reset
REQ-028 RST high at a clock edge forces the following on that edge, overriding all other inputs:
- state IDLE;
- prescaler, tick counter, start_d, period_q and remaining all 0;
- transition, done and busy all 0.
REQ-029 RST asserted mid-sequence aborts the sequence with no further pulses.
REQ-030 A start held high through reset release does not trigger a sequence; a new 0->1 edge is required.

Verification
REQ-031 The bench covers these scenarios, with PRESCALE=4 and start edge at edge k:
- Finite sequence: period=2, count=3 -> transition pulses after edges k+8, k+16, k+24; remaining 3->2->1->0; done coincident with the third pulse; busy low from edge k+24.
- Zero period: period=0, count=1 -> a single pulse after edge k+4; done with it; then IDLE.
- Continuous mode: period=1, count=0 -> a pulse every 4 cycles for 40 cycles; done never high. Then stop=1 -> busy low next edge; no further pulses.
- Stop on expiry: period=2, count=2, stop raised so it is sampled at edge k+8 -> no pulse at k+8; done never high; IDLE.
- Reset and restart: RST pulsed mid-sequence -> all outputs 0 next edge. With start held high across reset -> no new sequence until start toggles 0->1.
- Ignored inputs: second start edge and a period change during RUN -> original timing is unchanged.
